sign_conv_pipe: RTL and testbench



---
 rtl/sign_conv_pkg.sv | 15 +
 rtl/sign_conv_if.sv | 23 ++
 rtl/sign_conv_core.sv | 63 ++++++
 rtl/sign_conv_pipe.sv | 103 ++++++++++
 tb/tb_sign_conv_pipe.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sign_conv_pkg.sv
// Shared mode encoding for the sign_conv_pipe converter and its combinational core.
package sign_conv_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_U2S  = 2'b01,
        MODE_S2U  = 2'b10,
        MODE_ABS  = 2'b11
    } mode_t;

    function automatic mode_t to_mode(input logic [1:0] raw);
        return mode_t'(raw);
    endfunction

endpackage

// File: rtl/sign_conv_if.sv
// Producer-side and consumer-side valid/ready streams of the sign converter.
interface sign_conv_if #(
    parameter int W = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [1:0]   in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_sat;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/sign_conv_core.sv
// Combinational W-bit conversion: (value, mode) -> (converted value, saturation flag).
module sign_conv_core
    import sign_conv_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] in_val,
    input  mode_t        mode,
    output logic [W-1:0] out_val,
    output logic         sat
);

    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] ZERO    = {W{1'b0}};
    localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};

    // The top bit doubles as "above signed max" for U2S and "negative" for S2U/ABS.
    logic neg_s;
    assign neg_s = in_val[W-1];

    // Mode decode; ABS of the most negative value wraps to 2^(W-1), which is a valid unsigned result
    always_comb begin
        out_val = in_val;
        sat     = 1'b0;
        case (mode)
            MODE_PASS: begin
                out_val = in_val;
                sat     = 1'b0;
            end
            MODE_U2S: begin
                if (neg_s) begin
                    out_val = MAX_POS;
                    sat     = 1'b1;
                end else begin
                    out_val = in_val;
                    sat     = 1'b0;
                end
            end
            MODE_S2U: begin
                if (neg_s) begin
                    out_val = ZERO;
                    sat     = 1'b1;
                end else begin
                    out_val = in_val;
                    sat     = 1'b0;
                end
            end
            MODE_ABS: begin
                if (neg_s) begin
                    out_val = (~in_val) + ONE;
                end else begin
                    out_val = in_val;
                end
                sat = 1'b0;
            end
            default: begin
                out_val = in_val;
                sat     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sign_conv_pipe.sv
// Two-stage valid/ready signed/unsigned converter with saturation reporting.
// Define SIGN_CONV_SAT_CNT_EN to add the saturation counter (sat_clr / sat_count).
module sign_conv_pipe
    import sign_conv_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef SIGN_CONV_SAT_CNT_EN
    input  logic             sat_clr,
    output logic [CNT_W-1:0] sat_count,
`endif
    sign_conv_if.slave       bus
);

    logic         s1_valid_r;
    logic [W-1:0] s1_data_r;
    mode_t        s1_mode_r;
    logic         s2_valid_r;
    logic [W-1:0] s2_data_r;
    logic         s2_sat_r;

    logic [W-1:0] conv_data_s;
    logic         conv_sat_s;
    logic         s2_adv_s;
    logic         in_ready_s;
    logic         s1_load_s;

    // S1 may refill in the same cycle it hands its content to S2.
    assign s2_adv_s   = s1_valid_r && (!s2_valid_r || bus.out_ready);
    assign in_ready_s = !s1_valid_r || s2_adv_s;
    assign s1_load_s  = bus.in_valid && in_ready_s;

    // Stage 1: capture operand and mode on accept, empty when passed on
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= {W{1'b0}};
            s1_mode_r  <= MODE_PASS;
        end else if (s1_load_s) begin
            s1_valid_r <= 1'b1;
            s1_data_r  <= bus.in_data;
            s1_mode_r  <= to_mode(bus.in_mode);
        end else if (s2_adv_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    sign_conv_core #(
        .W(W)
    ) u_core (
        .in_val  (s1_data_r),
        .mode    (s1_mode_r),
        .out_val (conv_data_s),
        .sat     (conv_sat_s)
    );

    // Stage 2: register converted result; data holds while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_data_r  <= {W{1'b0}};
            s2_sat_r   <= 1'b0;
        end else if (s2_adv_s) begin
            s2_valid_r <= 1'b1;
            s2_data_r  <= conv_data_s;
            s2_sat_r   <= conv_sat_s;
        end else if (s2_valid_r && bus.out_ready) begin
            s2_valid_r <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = s2_valid_r;
    assign bus.out_data  = s2_data_r;
    assign bus.out_sat   = s2_sat_r;

`ifdef SIGN_CONV_SAT_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             out_fire_s;
    logic [CNT_W-1:0] sat_count_r;

    assign out_fire_s = s2_valid_r && bus.out_ready;

    // Saturating count of clamped results delivered; clear beats increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count_r <= {CNT_W{1'b0}};
        end else if (sat_clr) begin
            sat_count_r <= {CNT_W{1'b0}};
        end else if (out_fire_s && s2_sat_r && (sat_count_r != CNT_MAX)) begin
            sat_count_r <= sat_count_r + CNT_ONE;
        end
    end

    assign sat_count = sat_count_r;
`endif

endmodule

// File: tb/tb_sign_conv_pipe.sv
// Self-checking bench for sign_conv_pipe (W=4): directed vectors, stalls, reset, random traffic.
module tb_sign_conv_pipe;

    localparam int TW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sign_conv_if #(.W(TW)) bus ();

`ifdef SIGN_CONV_SAT_CNT_EN
    logic       sat_clr;
    logic [7:0] sat_count;
    sign_conv_pipe #(.W(TW), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .sat_clr(sat_clr), .sat_count(sat_count), .bus(bus)
    );
`else
    sign_conv_pipe #(.W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int del_cyc = 0;
    int model_cnt = 0;
    logic [4:0] exp_q[$];
    logic       acc;
    logic       del;
    logic [3:0] last_data;
    logic       last_sat;
    logic       hold_prev = 1'b0;
    logic [4:0] held;

    // Reference conversion from the mode rules, in integer arithmetic; returns {sat, value}.
    function automatic logic [4:0] ref_conv(input logic [3:0] d, input logic [1:0] m);
        int u, s, r;
        logic sat;
        u = int'(d);
        s = (u >= 8) ? u - 16 : u;
        r = u;
        sat = 1'b0;
        case (m)
            2'd0: r = u;
            2'd1: begin if (u > 7) begin r = 7; sat = 1'b1; end else r = u; end
            2'd2: begin if (s < 0) begin r = 0; sat = 1'b1; end else r = u; end
            default: r = (s < 0) ? -s : s;
        endcase
        return {sat, 4'(r)};
    endfunction

    // One clock: observe handshakes at the negedge, update scoreboard, advance past the posedge.
    task automatic step();
        logic [4:0] e;
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        del = bus.out_valid && bus.out_ready;
        if (hold_prev) begin
            checks++;
            if ({bus.out_valid, bus.out_sat, bus.out_data} !== {1'b1, held}) begin
                errors++;
                $display("FAIL hold_stable: got v=%0b sat=%0b data=%h expected v=1 sat=%0b data=%h",
                         bus.out_valid, bus.out_sat, bus.out_data, held[4], held[3:0]);
            end
        end
        hold_prev = bus.out_valid && !bus.out_ready;
        held = {bus.out_sat, bus.out_data};
        if (del) begin
            checks++;
            last_data = bus.out_data;
            last_sat  = bus.out_sat;
            del_cyc   = cyc;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got data=%h sat=%0b expected no output",
                         bus.out_data, bus.out_sat);
            end else begin
                e = exp_q.pop_front();
                if ({bus.out_sat, bus.out_data} !== e) begin
                    errors++;
                    $display("FAIL scoreboard: got data=%h sat=%0b expected data=%h sat=%0b",
                             bus.out_data, bus.out_sat, e[3:0], e[4]);
                end
            end
        end
`ifdef SIGN_CONV_SAT_CNT_EN
        if (sat_clr) model_cnt = 0;
        else if (del && bus.out_sat && model_cnt < 255) model_cnt++;
`endif
        if (acc) begin
            exp_q.push_back(ref_conv(bus.in_data, bus.in_mode));
            acc_cyc = cyc;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() != 0) step();
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 4'h0;
        bus.in_mode   = 2'b00;
        bus.out_ready = 1'b0;
`ifdef SIGN_CONV_SAT_CNT_EN
        sat_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_data !== 4'h0) begin errors++; $display("FAIL rst_out_data: got %h expected 0", bus.out_data); end
        checks++; if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL rst_out_sat: got %b expected 0", bus.out_sat); end
`ifdef SIGN_CONV_SAT_CNT_EN
        checks++; if (sat_count !== 8'd0) begin errors++; $display("FAIL rst_sat_count: got %0d expected 0", sat_count); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Single transfer into an idle pipeline: value, flag and two-cycle latency.
    task automatic send_one(input logic [3:0] d, input logic [1:0] m,
                            input logic [3:0] exp_d, input logic exp_s, input string name);
        logic got;
        got = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_mode   = m;
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (!acc) begin errors++; $display("FAIL %s_accept: got in_ready=0 expected 1", name); end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!got) begin
                step();
                got = del;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_timeout: got no output expected one", name);
        end else begin
            if ({last_sat, last_data} !== {exp_s, exp_d}) begin
                errors++;
                $display("FAIL %s: got data=%h sat=%0b expected data=%h sat=%0b", name, last_data, last_sat, exp_d, exp_s);
            end
            checks++;
            if (del_cyc - acc_cyc != 2) begin
                errors++;
                $display("FAIL %s_latency: got %0d expected 2", name, del_cyc - acc_cyc);
            end
        end
    endtask

    task automatic test_directed();
        send_one(4'b1111, 2'b01, 4'b0111, 1'b1, "u2s_clamp");
        send_one(4'b0110, 2'b01, 4'b0110, 1'b0, "u2s_pass");
        send_one(4'b1000, 2'b10, 4'b0000, 1'b1, "s2u_clamp");
        send_one(4'b0101, 2'b10, 4'b0101, 1'b0, "s2u_pass");
        send_one(4'b1000, 2'b11, 4'b1000, 1'b0, "abs_min");
        send_one(4'b1101, 2'b11, 4'b0011, 1'b0, "abs_neg");
        send_one(4'b1010, 2'b00, 4'b1010, 1'b0, "pass");
    endtask

    // From empty with the consumer stalled, exactly two transfers fit.
    task automatic test_stall_fill();
        int accepts;
        accepts = 0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in_data = 4'($urandom);
            bus.in_mode = 2'($urandom);
            step();
            if (acc) accepts++;
        end
        checks++;
        if (accepts != 2) begin errors++; $display("FAIL stall_accepts: got %0d expected 2", accepts); end
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", bus.in_ready); end
        drain();
    endtask

    task automatic test_backpressure();
        int sent, recv;
        sent = 0;
        recv = 0;
        bus.in_mode = 2'b00;
        for (int c = 0; c < 40; c++) begin
            if (sent < 10 || exp_q.size() != 0) begin
                bus.in_valid  = (sent < 10);
                bus.in_data   = 4'(sent);
                bus.out_ready = !(c >= 3 && c <= 8);
                step();
                if (acc) sent++;
                if (del) begin
                    checks++;
                    if (last_data !== 4'(recv)) begin
                        errors++;
                        $display("FAIL bp_order: got %h expected %h", last_data, 4'(recv));
                    end
                    recv++;
                end else if (c >= 9 && recv < 10) begin
                    checks++;
                    errors++;
                    $display("FAIL bp_gap: got no output in cycle %0d expected value %0d", c, recv);
                end
            end
        end
        checks++;
        if (recv != 10) begin errors++; $display("FAIL bp_count: got %0d expected 10", recv); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = 4'($urandom);
            bus.in_mode   = 2'($urandom);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        drain();
    endtask

`ifdef SIGN_CONV_SAT_CNT_EN
    task automatic test_sat_counter();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        bus.in_mode = 2'b01;
        for (int i = 0; i < 300; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 4'($urandom_range(8, 15));
            step();
        end
        drain();
        checks++;
        if (sat_count !== 8'(model_cnt) || model_cnt != 255) begin
            errors++;
            $display("FAIL cnt_saturate: got %0d expected 255", sat_count);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 4'hF;
        step();
        step();
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (!(del && last_sat)) begin errors++; $display("FAIL cnt_clr_collide: got no saturating handshake expected one"); end
        checks++;
        if (sat_count !== 8'd0) begin errors++; $display("FAIL cnt_clr: got %0d expected 0", sat_count); end
        drain();
        checks++;
        if (sat_count !== 8'(model_cnt)) begin errors++; $display("FAIL cnt_after_clr: got %0d expected %0d", sat_count, model_cnt); end
    endtask
`endif

    task automatic test_reset_midflight();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_mode   = 2'b01;
        bus.in_data   = 4'hF;
        step();
        bus.in_data   = 4'hE;
        step();
        bus.in_valid  = 1'b0;
        checks++;
        if (!(bus.out_valid === 1'b1 && bus.in_ready === 1'b0)) begin
            errors++;
            $display("FAIL mid_prefill: got out_valid=%b in_ready=%b expected 1 0", bus.out_valid, bus.in_ready);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_sat, bus.out_data} !== 7'b1000000) begin
            errors++;
            $display("FAIL mid_reset: got rdy=%b v=%b sat=%b data=%h expected 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_sat, bus.out_data);
        end
        exp_q.delete();
        hold_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_one(4'h9, 2'b01, 4'h7, 1'b1, "post_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall_fill();
        test_backpressure();
        test_random();
`ifdef SIGN_CONV_SAT_CNT_EN
        test_sat_counter();
`endif
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
